autocorr_product_gen: RTL and testbench
=======================================

Name: autocorr_product_gen

Overview:
- Upstream feeder of the RACE-filter exponential smoothing stage.
- For each accepted input sample x(n), emits the 2L+1 instantaneous autocorrelation products x(n)*x(n-k), k = 0..2L, serially, one per clock, in ascending lag order.
- Each product is accompanied by a one-cycle enable strobe that drives the smoother's en directly, so its circular tap buffer stays lag-aligned.

Parameters:
- L, 7, half-window; 2L+1 lags produced per sample.
- DATA_SIZE, 16, signed input sample width.
- OUT_SIZE, 17, signed product output width; equals the smoother's IN_SIZE.
- PROD_SHIFT, 15, right shift applied to the full product before output (rounded).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in  in  DATA_SIZE  signed input sample.
- in_valid  in  1  sample strobe; accepted only when in_ready=1.
- in_ready  out  1  high in IDLE; combinational from state.
- out  out  OUT_SIZE  signed scaled product for lag out_lag.
- out_en  out  1  one-cycle strobe per product; drives the smoother's en.
- out_lag  out  ceil(log2(2L+1))  lag index k of the current out.
- frame_start  out  1  high with out_en when out_lag=0.
- overrun  out  1  sticky flag: in_valid was seen while in_ready=0.

Behaviour:
- Interface (already decided): one clock (clk); reset rst is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset (rst=1 at an edge):
  - out=0, out_en=0, out_lag=0, frame_start=0, overrun=0.
  - History hist[0..2L]=0; state=IDLE, so in_ready=1 after the edge.
- History: hist[0] is the newest sample, hist[k]=x(n-k). It shifts only on acceptance: hist[k] <= hist[k-1], hist[0] <= in.
- State machine (IDLE, RUN):
  - IDLE: in_valid=1 at edge E0 -> accept, shift history, k<=0, go to RUN.
  - RUN: at each edge, register product(hist[0], hist[k]) into out, with out_lag<=k, out_en<=1, frame_start<=(k==0).
  - RUN: if k==2L go to IDLE, else k<=k+1.
- Timing:
  - out_en is high for exactly 2L+1 consecutive cycles, following edges E1..E(2L+1).
  - Latency from accept edge to first product: 1 cycle.
  - Minimum sample spacing is 2L+2 cycles; earliest next accept is E(2L+2).
- Ordering: lags always leave in order 0,1,..,2L with no gaps. A frame is never truncated except by reset. This is a hard requirement, because the smoother assigns taps purely by strobe count.
- Arithmetic:
  - p = signed(hist[0]) * signed(hist[k]), 2*DATA_SIZE bits.
  - r = (p + 2^(PROD_SHIFT-1)) >>> PROD_SHIFT, arithmetic shift, round half up.
  - Saturate r to the signed OUT_SIZE range.
  - With defaults, (-32768)^2 >> 15 = 32768 fits 17 bits, so no saturation occurs.
- Boundary conditions:
  - in_valid while in RUN: sample ignored, history untouched, overrun<=1 (sticky until rst).
  - in_valid at the edge where RUN->IDLE (k==2L): ignored, sets overrun, since in_ready=0 during that cycle.
  - Startup: history zeros give zero products for lags not yet filled. No special casing.
  - rst during RUN: frame aborted, out_en=0 from the next cycle, history cleared. The downstream smoother shares the reset, so alignment is preserved.

Decomposition:
- Shared package (RACE filter):
  - Constants N_LAGS = 2L+1 and LAG_W = clog2(N_LAGS).
  - State enum {IDLE, RUN}.
  - A signed-saturation function, also reused by the smoother.
- Sub-module round_sat_shift: signed input width, shift, output width; performs round-half-up arithmetic shift plus saturation. Purely combinational; the result is registered in autocorr_product_gen.

Test Plan:
- Reset then a single sample in=100 (prior history zero) -> 15 consecutive out_en; out_lag 0..14; out = (100*100+16384)>>>15 = 0 at lag 0, and 0 for all other lags; frame_start only on the first strobe.
- Samples 16384, then -16384 spaced 16 cycles apart -> second frame: lag0 = 8192, lag1 = -8192, lags 2..14 = 0.
- Sample -32768 twice -> second frame: lag0 = lag1 = 32768 (no saturation); rerun with OUT_SIZE=16 -> 32767.
- in_valid held high continuously -> accepts exactly every 16 cycles; overrun=1 after the first frame; history contains only the accepted samples.
- Assert rst at lag 6 of a frame -> out_en low from the next cycle; in_ready=1; next sample 200 yields lag0 = 1 and lags 1..14 = 0 (history cleared).
- Drive the output into the smoothing filter, with a constant input of 8192 for 40 frames -> smoother tap 0 converges toward 2048 and all taps stay aligned.

Source files
------------

// File: rtl/autocorr_product_gen_pkg.sv
// Shared RACE-filter definitions: lag-count constants, control state encoding
// and a signed saturation helper used by the product generator and the smoother.
package autocorr_product_gen_pkg;

  localparam int RACE_L = 7;
  localparam int N_LAGS = 2 * RACE_L + 1;
  localparam int LAG_W  = $clog2(N_LAGS);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Clamp a sign-extended value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int w);
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    if (v > mx) begin
      return mx;
    end else if (v < mn) begin
      return mn;
    end
    return v;
  endfunction

endpackage

// File: rtl/autocorr_product_gen_round_sat_shift.sv
// Combinational round-half-up arithmetic right shift followed by signed saturation.
// Zero latency; the caller registers the result.
module round_sat_shift
  import autocorr_product_gen_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int SHIFT = 15,
  parameter int OUT_W = 17
) (
  input  logic signed [IN_W-1:0]  val_i,
  output logic signed [OUT_W-1:0] res_o
);

  localparam int SW = IN_W + 1;
  localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [SW-1:0] HALF = (SHIFT > 0) ? (SW'(1) << HS) : '0;

  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  logic signed [SW-1:0] ext;
  logic signed [SW-1:0] shifted;
  logic signed [63:0]   wide;

  assign ext     = {val_i[IN_W-1], val_i};
  assign shifted = (ext + HALF) >>> SHIFT;
  assign wide    = 64'(shifted);
  assign res_o   = OUT_W'(sat_signed(wide, OUT_W));

endmodule

// File: rtl/autocorr_product_gen.sv
// Emits x(n)*x(n-k), k = 0..2L, one per clock after each accepted sample, with an
// enable strobe per product; new samples are refused (and flagged) while a frame runs.
module autocorr_product_gen
  import autocorr_product_gen_pkg::*;
#(
  parameter  int L          = 7,
  parameter  int DATA_SIZE  = 16,
  parameter  int OUT_SIZE   = 17,
  parameter  int PROD_SHIFT = 15,
  localparam int N_L        = 2 * L + 1,
  localparam int LW         = $clog2(N_L)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_SIZE-1:0] in,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_SIZE-1:0]  out,
  output logic                        out_en,
  output logic [LW-1:0]               out_lag,
  output logic                        frame_start,
  output logic                        overrun
);

  state_e                      state_q, state_d;
  logic [LW-1:0]               k_q, k_d;
  logic signed [DATA_SIZE-1:0] hist_q [N_L];
  logic signed [DATA_SIZE-1:0] hist_d [N_L];
  logic signed [OUT_SIZE-1:0]  out_q, out_d;
  logic                        out_en_q, out_en_d;
  logic [LW-1:0]               out_lag_q, out_lag_d;
  logic                        frame_start_q, frame_start_d;
  logic                        overrun_q, overrun_d;

  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [OUT_SIZE-1:0]    prod_rs;

  assign prod = hist_q[0] * hist_q[k_q];

  round_sat_shift #(
    .IN_W (2 * DATA_SIZE),
    .SHIFT(PROD_SHIFT),
    .OUT_W(OUT_SIZE)
  ) u_round_sat_shift (
    .val_i(prod),
    .res_o(prod_rs)
  );

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    hist_d        = hist_q;
    out_d         = out_q;
    out_en_d      = 1'b0;
    out_lag_d     = out_lag_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q | (in_valid & ~in_ready);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = N_L - 1; i > 0; i--) begin
            hist_d[i] = hist_q[i-1];
          end
          hist_d[0] = in;
          k_d       = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        out_d         = prod_rs;
        out_lag_d     = k_q;
        out_en_d      = 1'b1;
        frame_start_d = (k_q == '0);
        // The frame always runs to the last lag so downstream tap counting stays aligned.
        if (k_q == LW'(N_L - 1)) begin
          state_d = IDLE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      k_q           <= '0;
      out_q         <= '0;
      out_en_q      <= 1'b0;
      out_lag_q     <= '0;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < N_L; i++) begin
        hist_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      out_q         <= out_d;
      out_en_q      <= out_en_d;
      out_lag_q     <= out_lag_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      for (int i = 0; i < N_L; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign out         = out_q;
  assign out_en      = out_en_q;
  assign out_lag     = out_lag_q;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_autocorr_product_gen.sv
// Directed bench with a reference model and scoreboard; a second instance with a
// 16-bit output checks saturation alongside the default 17-bit instance.
module tb_autocorr_product_gen;
  import autocorr_product_gen_pkg::*;

  localparam int SHIFT = 15;

  logic               clk;
  logic               rst;
  logic signed [15:0] in_s;
  logic               in_valid;

  logic               in_ready;
  logic signed [16:0] out17;
  logic               out_en;
  logic [3:0]         out_lag;
  logic               frame_start;
  logic               overrun;

  logic               in_ready16;
  logic signed [15:0] out16;
  logic               out_en16;
  logic [3:0]         out_lag16;
  logic               frame_start16;
  logic               overrun16;

  autocorr_product_gen #(.L(7), .DATA_SIZE(16), .OUT_SIZE(17), .PROD_SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid), .in_ready(in_ready),
    .out(out17), .out_en(out_en), .out_lag(out_lag), .frame_start(frame_start),
    .overrun(overrun)
  );

  autocorr_product_gen #(.L(7), .DATA_SIZE(16), .OUT_SIZE(16), .PROD_SHIFT(SHIFT)) dut16 (
    .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid), .in_ready(in_ready16),
    .out(out16), .out_en(out_en16), .out_lag(out_lag16), .frame_start(frame_start16),
    .overrun(overrun16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [16:0] v17;
    logic signed [15:0] v16;
    logic [3:0]         lag;
    logic               fs;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nfail = 0;
  bit   mon_on = 1'b0;

  longint mh [N_LAGS];
  int     m_cnt = 0;
  bit     m_en = 1'b0;
  bit     m_ovr = 1'b0;

  function automatic longint rs(input longint p, input int ow);
    longint r;
    longint mx;
    r  = (p + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    if (r > mx) r = mx;
    if (r < -mx - 1) r = -mx - 1;
    return r;
  endfunction

  // Reference model: updated on the same edges the DUT uses.
  always @(posedge clk) begin
    bit rdy;
    exp_t e;
    if (rst) begin
      for (int i = 0; i < N_LAGS; i++) mh[i] = 0;
      m_cnt = 0;
      m_en  = 1'b0;
      m_ovr = 1'b0;
      sbq.delete();
    end else begin
      rdy = (m_cnt == 0);
      if (in_valid && !rdy) m_ovr = 1'b1;
      m_en = !rdy;
      if (!rdy) m_cnt--;
      if (in_valid && rdy) begin
        for (int i = N_LAGS - 1; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = longint'(in_s);
        for (int k = 0; k < N_LAGS; k++) begin
          e.v17 = 17'(rs(mh[0] * mh[k], 17));
          e.v16 = 16'(rs(mh[0] * mh[k], 16));
          e.lag = 4'(k);
          e.fs  = (k == 0);
          sbq.push_back(e);
        end
        m_cnt = N_LAGS;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      nchk++;
      assert (out_en === m_en) else begin
        nfail++; $error("FAIL out_en obs=%b exp=%b", out_en, m_en);
      end
      nchk++;
      assert (in_ready === (m_cnt == 0)) else begin
        nfail++; $error("FAIL in_ready obs=%b exp=%b", in_ready, (m_cnt == 0));
      end
      nchk++;
      assert (overrun === m_ovr) else begin
        nfail++; $error("FAIL overrun obs=%b exp=%b", overrun, m_ovr);
      end
      if (out_en === 1'b1) begin
        nchk++;
        assert (sbq.size() > 0) else begin
          nfail++; $error("FAIL unexpected_strobe obs=%0d exp=>0 queued", sbq.size());
        end
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          nchk++;
          assert (out17 === e.v17) else begin
            nfail++; $error("FAIL out lag%0d obs=%0d exp=%0d", e.lag, out17, e.v17);
          end
          nchk++;
          assert (out16 === e.v16) else begin
            nfail++; $error("FAIL out16 lag%0d obs=%0d exp=%0d", e.lag, out16, e.v16);
          end
          nchk++;
          assert (out_lag === e.lag) else begin
            nfail++; $error("FAIL out_lag obs=%0d exp=%0d", out_lag, e.lag);
          end
          nchk++;
          assert (frame_start === e.fs) else begin
            nfail++; $error("FAIL frame_start lag%0d obs=%b exp=%b", e.lag, frame_start, e.fs);
          end
        end
      end
    end
  end

  task automatic send_nowait(input logic signed [15:0] x);
    in_s     = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] x);
    send_nowait(x);
    repeat (N_LAGS + 1) @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    in_s     = '0;
    in_valid = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    nchk++;
    assert (out17 === 17'sd0) else begin
      nfail++; $error("FAIL reset_out obs=%0d exp=0", out17);
    end
    nchk++;
    assert (out_lag === 4'd0) else begin
      nfail++; $error("FAIL reset_out_lag obs=%0d exp=0", out_lag);
    end
    nchk++;
    assert (frame_start === 1'b0) else begin
      nfail++; $error("FAIL reset_frame_start obs=%b exp=0", frame_start);
    end
    nchk++;
    assert (in_ready === 1'b1) else begin
      nfail++; $error("FAIL reset_in_ready obs=%b exp=1", in_ready);
    end
    @(negedge clk);

    send(16'sd100);

    send(16'sd16384);
    send(-16'sd16384);

    send(-16'sd32768);
    send(-16'sd32768);

    // Continuous in_valid with changing data: only every 16th cycle may be taken.
    in_valid = 1'b1;
    for (int c = 0; c < 5 * (N_LAGS + 1); c++) begin
      in_s = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (N_LAGS + 1) @(negedge clk);
    nchk++;
    assert (overrun === 1'b1) else begin
      nfail++; $error("FAIL overrun_sticky obs=%b exp=1", overrun);
    end

    // Reset in the middle of a frame.
    send_nowait(16'sd300);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nchk++;
    assert (out_en === 1'b0) else begin
      nfail++; $error("FAIL abort_out_en obs=%b exp=0", out_en);
    end
    nchk++;
    assert (in_ready === 1'b1) else begin
      nfail++; $error("FAIL abort_in_ready obs=%b exp=1", in_ready);
    end
    nchk++;
    assert (overrun === 1'b0) else begin
      nfail++; $error("FAIL abort_overrun obs=%b exp=0", overrun);
    end
    send(16'sd200);

    for (int f = 0; f < 20; f++) send(16'sd8192);

    repeat (4) @(negedge clk);
    nchk++;
    assert (sbq.size() == 0) else begin
      nfail++; $error("FAIL missing_products obs=%0d exp=0 left", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
